// File: rtl/program_loader_if.sv
// Byte-stream and memory-write bus for program_loader.
// master: stream source and memory sink. slave: the loader.
interface program_loader_if #(
  parameter int WIDTH_REG         = 8,
  parameter int WIDTH_ADDRESS_BIT = 5
);
  logic                         in_valid;
  logic [WIDTH_REG-1:0]         in_data;
  logic                         in_ready;
  logic [WIDTH_ADDRESS_BIT-1:0] mem_addr;
  logic [WIDTH_REG-1:0]         mem_wdata;
  logic                         mem_wr;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. It takes a length byte and then L image bytes from a
// valid/ready stream and writes them to CPU memory from address 0. It holds
// the CPU in reset during the load, then releases it and tracks its HALT flag.
// Optional: define LOADER_CHECKSUM_EN to require a trailing checksum byte.
// The checksum byte must make the 8-bit sum of the data bytes plus C equal
// zero. A bad checksum parks the loader in ERR.
// All outputs are decoded from the next state or next datapath values, so they
// are registered and line up with the state that they describe.
module program_loader #(
  parameter int WIDTH_REG         = 8,
  parameter int WIDTH_ADDRESS_BIT = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.slave   bus,
  input  logic              cpu_halt,
  output logic              cpu_reset,
  output logic              busy,
  output logic              running,
  output logic              halted,
  output logic              error
);

  localparam int DEPTH = 2 ** WIDTH_ADDRESS_BIT;
  localparam int CW    = WIDTH_ADDRESS_BIT + 1;  // counter reaches DEPTH

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, HDR, LOAD, RELEASE, RUN, HALTED, CHK, ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, HDR, LOAD, RELEASE, RUN, HALTED
  } state_t;
`endif

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CW-1:0]                len_q, len_d;
  logic                         in_ready_q, in_ready_d;
  logic                         mem_wr_q, mem_wr_d;
  logic [WIDTH_ADDRESS_BIT-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH_REG-1:0]         mem_wdata_q, mem_wdata_d;
  logic                         cpu_reset_q, cpu_reset_d;
  logic                         busy_q, busy_d;
  logic                         running_q, running_d;
  logic                         halted_q, halted_d;

  logic                         accept;
  logic [CW-1:0]                hdr_len;
  logic [CW-1:0]                cnt_inc;

  assign accept  = bus.in_valid & in_ready_q;
  assign hdr_len = bus.in_data[CW-1:0];
  assign cnt_inc = cnt_q + CW'(1);

`ifdef LOADER_CHECKSUM_EN
  logic [WIDTH_REG-1:0] sum_q, sum_d;
  logic [WIDTH_REG-1:0] chk_sum;
  logic                 error_q, error_d;
  assign chk_sum = sum_q + bus.in_data;
  assign error   = error_q;
`else
  assign error   = 1'b0;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE:    if (start) state_d = HDR;
      HDR: begin
        if (accept) begin
          // Zero or oversize length means a full-depth image
          if (hdr_len == '0 || hdr_len > CW'(DEPTH)) len_d = CW'(DEPTH);
          else                                       len_d = hdr_len;
          cnt_d   = '0;
          state_d = LOAD;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = cnt_q[WIDTH_ADDRESS_BIT-1:0];
          mem_wdata_d = bus.in_data;
          cnt_d       = cnt_inc;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + bus.in_data;
          if (cnt_inc == len_q) state_d = CHK;
`else
          if (cnt_inc == len_q) state_d = RELEASE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (chk_sum == '0) ? RELEASE : ERR;
      end
      ERR:     if (start) state_d = HDR;
`endif
      // One cycle so the last write lands while the CPU is still in reset
      RELEASE: state_d = RUN;
      RUN: begin
        if (start)         state_d = HDR;
        else if (cpu_halt) state_d = HALTED;
      end
      HALTED:  if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == HDR) || (state_d == LOAD);
    busy_d      = (state_d == HDR) || (state_d == LOAD) || (state_d == RELEASE);
`ifdef LOADER_CHECKSUM_EN
    in_ready_d  = in_ready_d || (state_d == CHK);
    busy_d      = busy_d || (state_d == CHK);
    error_d     = (state_d == ERR);
`endif
    cpu_reset_d = !((state_d == RUN) || (state_d == HALTED));
    running_d   = (state_d == RUN);
    halted_d    = (state_d == HALTED);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      in_ready_q  <= in_ready_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
      error_q     <= error_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign running       = running_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a per-cycle vector table, plus sequences
// for a full-depth stream with a stall and for an asynchronous reset mid-load.
module tb_program_loader;
  localparam int W = 8;
  localparam int A = 5;

  logic clk = 1'b0;
  logic reset, start, cpu_halt;
  logic cpu_reset, busy, running, halted, error;

  always #5 clk = ~clk;

  program_loader_if #(.WIDTH_REG(W), .WIDTH_ADDRESS_BIT(A)) bus ();

  program_loader #(.WIDTH_REG(W), .WIDTH_ADDRESS_BIT(A)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .cpu_halt(cpu_halt), .cpu_reset(cpu_reset), .busy(busy),
    .running(running), .halted(halted), .error(error)
  );

  typedef struct {
    string      name;
    logic       start, vld;
    logic [7:0] data;
    logic       halt;
    logic       ir, wr;
    logic [4:0] addr;
    logic [7:0] wd;
    logic       cr, bsy, run, hlt, err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic add(string n, logic s, logic v, logic [7:0] d, logic h,
                     logic ir, logic wr, logic [4:0] a, logic [7:0] wd,
                     logic cr, logic b, logic r, logic hl, logic e);
    vec_t x;
    x.name = n; x.start = s; x.vld = v; x.data = d; x.halt = h;
    x.ir = ir; x.wr = wr; x.addr = a; x.wd = wd;
    x.cr = cr; x.bsy = b; x.run = r; x.hlt = hl; x.err = e;
    tbl.push_back(x);
  endtask

  task automatic check_outs(vec_t x);
    check({x.name, ".in_ready"},  32'(bus.in_ready), 32'(x.ir));
    check({x.name, ".mem_wr"},    32'(bus.mem_wr),   32'(x.wr));
    if (x.wr) begin
      check({x.name, ".mem_addr"},  32'(bus.mem_addr),  32'(x.addr));
      check({x.name, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(x.wd));
    end
    check({x.name, ".cpu_reset"}, 32'(cpu_reset), 32'(x.cr));
    check({x.name, ".busy"},      32'(busy),      32'(x.bsy));
    check({x.name, ".running"},   32'(running),   32'(x.run));
    check({x.name, ".halted"},    32'(halted),    32'(x.hlt));
    check({x.name, ".error"},     32'(error),     32'(x.err));
  endtask

  // Write monitor for the long stream: addresses must run 0,1,2,... in order
  logic       mon_en = 1'b0;
  int         wr_cnt = 0;
  logic [7:0] img [32];

  always @(negedge clk) begin
    if (mon_en && bus.mem_wr) begin
      check("seq2.addr",  32'(bus.mem_addr),  32'(wr_cnt));
      check("seq2.wdata", 32'(bus.mem_wdata), 32'(img[wr_cnt % 32]));
      wr_cnt++;
    end
  end

  // Present one byte and wait (bounded) for it to be accepted
  task automatic send_byte(string n, logic [7:0] d);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 10 && !done; k++) begin
      if (bus.in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) check({n, ".accept_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] sum;
    bit         seen;
    reset = 1'b1; start = 1'b0; cpu_halt = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;

    // Vectors: inputs before the edge, expected outputs after it
    add("t1_start", 1,0,8'h00,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t1_len",   0,1,8'h03,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t1_b0",    0,1,8'hA1,0, 1,1,0,8'hA1, 1,1,0,0,0);
    add("t1_b1",    1,1,8'hB2,0, 1,1,1,8'hB2, 1,1,0,0,0); // start ignored
`ifdef LOADER_CHECKSUM_EN
    add("t1_b2",    0,1,8'hC3,0, 1,1,2,8'hC3, 1,1,0,0,0);
    add("t1_chk",   0,1,8'hEA,0, 0,0,0,8'h00, 1,1,0,0,0);
`else
    add("t1_b2",    0,1,8'hC3,0, 0,1,2,8'hC3, 1,1,0,0,0);
`endif
    add("t1_run",   0,0,8'h00,0, 0,0,0,8'h00, 0,0,1,0,0);
    add("t1_run2",  0,1,8'h77,0, 0,0,0,8'h00, 0,0,1,0,0);
    add("t3_halt",  0,0,8'h00,1, 0,0,0,8'h00, 0,0,0,1,0);
    add("t3_hold",  0,0,8'h00,0, 0,0,0,8'h00, 0,0,0,1,0);
    add("t3_start", 1,0,8'h00,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t3_len41", 0,1,8'h41,0, 1,0,0,8'h00, 1,1,0,0,0); // low 6 bits -> L=1
`ifdef LOADER_CHECKSUM_EN
    add("t3_b0",    0,1,8'h55,0, 1,1,0,8'h55, 1,1,0,0,0);
    add("t3_chk",   0,1,8'hAB,0, 0,0,0,8'h00, 1,1,0,0,0);
`else
    add("t3_b0",    0,1,8'h55,0, 0,1,0,8'h55, 1,1,0,0,0);
`endif
    add("t3_run",   0,0,8'h00,0, 0,0,0,8'h00, 0,0,1,0,0);
`ifdef LOADER_CHECKSUM_EN
    add("t5_start", 1,0,8'h00,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t5_len",   0,1,8'h02,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t5_b0",    0,1,8'h10,0, 1,1,0,8'h10, 1,1,0,0,0);
    add("t5_b1",    0,1,8'h20,0, 1,1,1,8'h20, 1,1,0,0,0);
    add("t5_good",  0,1,8'hD0,0, 0,0,0,8'h00, 1,1,0,0,0);
    add("t5_run",   0,0,8'h00,0, 0,0,0,8'h00, 0,0,1,0,0);
    add("t6_start", 1,0,8'h00,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t6_len",   0,1,8'h02,0, 1,0,0,8'h00, 1,1,0,0,0);
    add("t6_b0",    0,1,8'h10,0, 1,1,0,8'h10, 1,1,0,0,0);
    add("t6_b1",    0,1,8'h20,0, 1,1,1,8'h20, 1,1,0,0,0);
    add("t6_bad",   0,1,8'hD1,0, 0,0,0,8'h00, 1,0,0,0,1);
    add("t6_stick", 0,1,8'h00,0, 0,0,0,8'h00, 1,0,0,0,1);
    add("t6_clear", 1,0,8'h00,0, 1,0,0,8'h00, 1,1,0,0,0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst.cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst.in_ready",  32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    begin
      vec_t r;
      r.name = "idle"; r.ir = 0; r.wr = 0; r.addr = 0; r.wd = 0;
      r.cr = 1; r.bsy = 0; r.run = 0; r.hlt = 0; r.err = 0;
      check_outs(r);
      check("idle.mem_addr",  32'(bus.mem_addr),  32'd0);
      check("idle.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    end

    foreach (tbl[i]) begin
      start = tbl[i].start; bus.in_valid = tbl[i].vld;
      bus.in_data = tbl[i].data; cpu_halt = tbl[i].halt;
      @(posedge clk); #1;
      check_outs(tbl[i]);
    end
    start = 1'b0; bus.in_valid = 1'b0; cpu_halt = 1'b0;

    // Full-depth image with L=0 and a four-cycle stall midway
    for (int i = 0; i < 32; i++) img[i] = 8'((i * 5) + 1);
    wr_cnt = 0; mon_en = 1'b1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send_byte("seq2.len", 8'h00);
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        repeat (4) @(posedge clk);
        #1;
      end
      send_byte("seq2.data", img[i]);
      sum = sum + img[i];
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte("seq2.chk", 8'(-sum));
`endif
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (running) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("seq2.running", 32'(seen), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("seq2.write_count", 32'(wr_cnt), 32'd32);
    mon_en = 1'b0;

    // Async reset after 2 of 5 bytes while a write strobe is up
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    send_byte("seq3.len", 8'h05);
    send_byte("seq3.b0", 8'h11);
    send_byte("seq3.b1", 8'h22);
    check("seq3.pre_wr", 32'(bus.mem_wr), 32'd1);
    check("seq3.pre_cpu_reset", 32'(cpu_reset), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("seq3.mem_wr",    32'(bus.mem_wr),   32'd0);
    check("seq3.cpu_reset", 32'(cpu_reset),    32'd1);
    check("seq3.in_ready",  32'(bus.in_ready), 32'd0);
    check("seq3.busy",      32'(busy),         32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("seq3.idle_ready", 32'(bus.in_ready), 32'd0);
    check("seq3.idle_wr",    32'(bus.mem_wr),   32'd0);
    check("seq3.idle_busy",  32'(busy),         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
